// File: rtl/sdram_bus_bridge.sv
// Bridges 32-bit CPU memory requests onto a 16-bit SDRAM controller one halfword at a time,
// using read-modify-write for halves with exactly one byte strobe set.
module sdram_bus_bridge #(
   parameter int unsigned HADDR_WIDTH = 22,
   parameter int unsigned TIMEOUT     = 1023
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sel,
   input  logic                   mem_valid,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_wstrb,
   output logic                   mem_ready,
   output logic [31:0]            mem_rdata,
   output logic [HADDR_WIDTH-1:0] sd_addr,
   output logic [15:0]            sd_wr_data,
   output logic                   sd_wr_enable,
   output logic                   sd_rd_enable,
   input  logic [15:0]            sd_rd_data,
   input  logic                   sd_rd_ready,
   input  logic                   sd_busy,
   output logic                   err
);

   localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, RREQ, RWAIT, WREQ, WWAIT, RESP} state_t;
   state_t state, state_n;

   logic [HADDR_WIDTH-2:0] addr_q;
   logic [31:0]            wdata_q;
   logic [3:0]             wstrb_q;
   logic                   half_q;
   logic [15:0]            lo_q, hi_q, rd_q;
   logic                   busy_seen, to_q;
   logic [CW-1:0]          cnt;

   logic                   accept, capture, go_high, timeout;
   logic                   is_read, hi_needed, hi_partial;
   logic                   in_read, in_first_lo, in_first_rreq;
   logic [1:0]             cur_strb, in_strb;
   logic [15:0]            cur_wdata, merged;
   logic                   unused_addr;

   assign unused_addr = ^{mem_addr[31:HADDR_WIDTH+1], mem_addr[1:0]};

   assign is_read    = (wstrb_q == 4'b0000);
   assign hi_needed  = is_read || (wstrb_q[3:2] != 2'b00);
   assign hi_partial = ^wstrb_q[3:2];
   assign cur_strb   = half_q ? wstrb_q[3:2] : wstrb_q[1:0];
   assign cur_wdata  = half_q ? wdata_q[31:16] : wdata_q[15:0];
   // A full-half write has both strobes set, so the merge passes wdata through untouched.
   assign merged     = {cur_strb[1] ? cur_wdata[15:8] : rd_q[15:8],
                        cur_strb[0] ? cur_wdata[7:0]  : rd_q[7:0]};

   assign in_read       = (mem_wstrb == 4'b0000);
   assign in_first_lo   = in_read || (mem_wstrb[1:0] != 2'b00);
   assign in_strb       = in_first_lo ? mem_wstrb[1:0] : mem_wstrb[3:2];
   assign in_first_rreq = in_read || (^in_strb);

   assign sd_addr    = {addr_q, half_q};
   assign sd_wr_data = (state == WREQ) ? merged : '0;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n      = state;
      accept       = 1'b0;
      capture      = 1'b0;
      go_high      = 1'b0;
      timeout      = 1'b0;
      sd_rd_enable = 1'b0;
      sd_wr_enable = 1'b0;
      mem_ready    = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_valid && sel) begin
               accept  = 1'b1;
               state_n = in_first_rreq ? RREQ : WREQ;
            end
         end
         RREQ: begin
            if (!sd_busy) begin
               sd_rd_enable = 1'b1;
               state_n      = RWAIT;
            end
         end
         WREQ: begin
            if (!sd_busy) begin
               sd_wr_enable = 1'b1;
               state_n      = WWAIT;
            end
         end
         RWAIT: begin
            if (sd_rd_ready) begin
               capture = 1'b1;
               if (!is_read) begin
                  state_n = WREQ;
               end else if (!half_q && hi_needed) begin
                  go_high = 1'b1;
                  state_n = RREQ;
               end else begin
                  state_n = RESP;
               end
            end else if (cnt == TMAX) begin
               timeout = 1'b1;
               state_n = RESP;
            end
         end
         WWAIT: begin
            if (busy_seen && !sd_busy) begin
               if (!half_q && hi_needed) begin
                  go_high = 1'b1;
                  state_n = hi_partial ? RREQ : WREQ;
               end else begin
                  state_n = RESP;
               end
            end else if (cnt == TMAX) begin
               timeout = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            mem_ready = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Outputs are combinational; keep them quiet in the reset cycle so an abandoned
      // transaction cannot leak a pulse.
      if (reset) begin
         sd_rd_enable = 1'b0;
         sd_wr_enable = 1'b0;
         mem_ready    = 1'b0;
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (state == RESP && !reset) begin
         if (to_q)         mem_rdata = '1;
         else if (is_read) mem_rdata = {hi_q, lo_q};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         half_q    <= 1'b0;
         lo_q      <= '0;
         hi_q      <= '0;
         rd_q      <= '0;
         busy_seen <= 1'b0;
         to_q      <= 1'b0;
         cnt       <= '0;
         err       <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= mem_addr[HADDR_WIDTH:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            half_q  <= ~in_first_lo;
            lo_q    <= '0;
            hi_q    <= '0;
            to_q    <= 1'b0;
         end
         if (go_high) half_q <= 1'b1;
         if (capture) begin
            rd_q <= sd_rd_data;
            if (is_read) begin
               if (half_q) hi_q <= sd_rd_data;
               else        lo_q <= sd_rd_data;
            end
         end
         if (timeout) begin
            to_q <= 1'b1;
            err  <= 1'b1;
         end
         if ((state_n == RWAIT || state_n == WWAIT) && state_n != state) begin
            cnt       <= '0;
            busy_seen <= 1'b0;
         end else if (state == RWAIT || state == WWAIT) begin
            cnt <= cnt + CW'(1);
            if (sd_busy) busy_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Randomized bench for sdram_bus_bridge: a reactive SDRAM controller model plus a
// transaction-level reference that predicts the halfword operations and read data.
module tb_sdram_bus_bridge;
   localparam int unsigned HW = 22;
   localparam int unsigned TO = 50;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sel = 1'b0;
   logic          mem_valid = 1'b0;
   logic [31:0]   mem_addr = '0;
   logic [31:0]   mem_wdata = '0;
   logic [3:0]    mem_wstrb = '0;
   logic          mem_ready;
   logic [31:0]   mem_rdata;
   logic [HW-1:0] sd_addr;
   logic [15:0]   sd_wr_data;
   logic          sd_wr_enable;
   logic          sd_rd_enable;
   logic [15:0]   sd_rd_data;
   logic          sd_rd_ready;
   logic          sd_busy;
   logic          err;

   always #5 clk = ~clk;

   sdram_bus_bridge #(.HADDR_WIDTH(HW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .sel(sel), .mem_valid(mem_valid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .sd_addr(sd_addr),
      .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable), .sd_rd_enable(sd_rd_enable),
      .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy), .err(err)
   );

   typedef struct packed {
      logic          wr;
      logic [HW-1:0] a;
      logic [15:0]   d;
   } op_t;

   op_t         ops[$];
   logic [15:0] sdmem [int unsigned];
   int unsigned n_vec = 0, n_bad = 0, n_ready = 0;
   bit          force_busy = 1'b0, mute = 1'b0;
   int unsigned fix_lat = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_rd(input int unsigned a);
      if (sdmem.exists(a)) return sdmem[a];
      return 16'(a * 40503 + 23130);
   endfunction

   // Controller model: observes enables mid-cycle, answers after a short latency.
   initial begin : sd_model
      int unsigned busy_left, rd_left, d;
      logic [15:0] rd_val;
      logic nb, nr, real_rd;
      busy_left = 0; rd_left = 0; rd_val = '0;
      sd_busy = 1'b0; sd_rd_ready = 1'b0; sd_rd_data = '0;
      forever begin
         @(negedge clk);
         if (mem_ready) n_ready++;
         else check("rdata_idle", 64'(mem_rdata), 64'd0);
         if (sd_rd_enable || sd_wr_enable) begin
            check("en_excl", 64'(sd_rd_enable & sd_wr_enable), 64'd0);
            check("en_busy", 64'(sd_busy), 64'd0);
            ops.push_back('{sd_wr_enable, sd_addr, sd_wr_enable ? sd_wr_data : 16'h0});
            d = (fix_lat != 0) ? fix_lat : $urandom_range(3, 1);
            busy_left = d;
            if (sd_rd_enable) begin
               rd_left = d;
               rd_val  = mem_rd(32'(sd_addr));
            end else begin
               sdmem[32'(sd_addr)] = sd_wr_data;
            end
         end
         nb = (busy_left != 0) || force_busy || (!mute && $urandom_range(5) == 0);
         nr = 1'b0;
         real_rd = 1'b0;
         if (busy_left != 0) busy_left--;
         if (rd_left != 0) begin
            rd_left--;
            real_rd = (rd_left == 0) && !mute;
            nr = real_rd;
         end else if (!mute && $urandom_range(7) == 0) begin
            nr = 1'b1;
         end
         @(posedge clk); #1;
         sd_busy     = nb;
         sd_rd_ready = nr;
         sd_rd_data  = real_rd ? rd_val : 16'($urandom);
      end
   end

   task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output logic [31:0] got);
      op_t           exp_ops[$];
      logic [HW-1:0] ha [2];
      logic [31:0]   exp_rd;
      logic [1:0]    s;
      logic [15:0]   old, nw;
      int unsigned   r0;
      bit            seen;
      exp_rd = '0;
      ha[0] = HW'(((addr >> 2) & ((32'd1 << (HW - 1)) - 32'd1)) << 1);
      ha[1] = ha[0] | HW'(1);
      for (int h = 0; h < 2; h++) begin
         s   = wstrb[2*h +: 2];
         old = mem_rd(32'(ha[h]));
         nw  = wdata[16*h +: 16];
         if (wstrb == 4'b0000) begin
            exp_ops.push_back('{1'b0, ha[h], 16'h0});
            exp_rd[16*h +: 16] = old;
         end else if (s == 2'b11) begin
            exp_ops.push_back('{1'b1, ha[h], nw});
         end else if (s != 2'b00) begin
            exp_ops.push_back('{1'b0, ha[h], 16'h0});
            for (int b = 0; b < 2; b++)
               if (!s[b]) nw[8*b +: 8] = old[8*b +: 8];
            exp_ops.push_back('{1'b1, ha[h], nw});
         end
      end
      @(posedge clk); #1;
      ops.delete();
      r0 = n_ready;
      mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
      mem_valid = 1'b1; sel = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (mem_ready) seen = 1'b1;
      end
      check("ready_seen", 64'(seen), 64'd1);
      got = mem_rdata;
      check("rdata", 64'(mem_rdata), 64'(exp_rd));
      check("err_clear", 64'(err), 64'd0);
      @(posedge clk); #1;
      mem_valid = 1'b0; sel = 1'(($urandom)); mem_wstrb = 4'($urandom);
      @(negedge clk);
      check("ready_pulse", 64'(mem_ready), 64'd0);
      check("ready_count", 64'(n_ready), 64'(r0 + 1));
      check("nops", 64'(ops.size()), 64'(exp_ops.size()));
      for (int i = 0; i < exp_ops.size(); i++)
         if (i < ops.size()) check("op", 64'(ops[i]), 64'(exp_ops[i]));
   endtask

   task automatic idle_cycles(input int unsigned n);
      int unsigned r0, o0;
      r0 = n_ready;
      o0 = ops.size();
      for (int i = 0; i < int'(n); i++) begin
         @(posedge clk); #1;
         mem_valid = 1'($urandom); sel = 1'b0;
         mem_addr = $urandom; mem_wstrb = 4'($urandom);
      end
      @(posedge clk); #1;
      mem_valid = 1'b0;
      @(negedge clk);
      check("idle_ops", 64'(ops.size()), 64'(o0));
      check("idle_ready", 64'(n_ready), 64'(r0));
   endtask

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] got, a;
      int unsigned r0, el;
      bit          seen;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(mem_ready), 64'd0);
      check("rst_rdata", 64'(mem_rdata), 64'd0);
      check("rst_en", 64'({sd_rd_enable, sd_wr_enable}), 64'd0);
      check("rst_addr", 64'(sd_addr), 64'd0);
      check("rst_wdata", 64'(sd_wr_data), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      sdmem[8] = 16'h1234; sdmem[9] = 16'hABCD;
      do_txn(32'h0400_0010, 32'h0, 4'b0000, got);
      check("d_read", 64'(got), 64'h0000_0000_ABCD_1234);

      do_txn(32'h0400_0020, 32'hCAFE_BABE, 4'b1111, got);
      if (ops.size() == 2) check("d_full_wr", 64'({ops[0], ops[1]}),
                                 64'({1'b1, 22'h10, 16'hBABE, 1'b1, 22'h11, 16'hCAFE}) );

      sdmem[32] = 16'h1122;
      do_txn(32'h0000_0040, 32'h0000_5A00, 4'b0010, got);
      check("d_rmw_mem", 64'(mem_rd(32)), 64'h5A22);

      do_txn(32'h0000_0080, 32'h7788_0000, 4'b1100, got);
      check("d_hi_only", 64'(ops.size()), 64'd1);

      idle_cycles(5);

      for (int t = 0; t < 150; t++) begin
         a = ($urandom & 32'hFF80_0003) | (32'($urandom_range(31)) << 2);
         do_txn(a, $urandom, ($urandom_range(3) == 0) ? 4'b0000 : 4'($urandom), got);
         if ($urandom_range(3) == 0) idle_cycles($urandom_range(4, 1));
      end

      // Busy held off, then a read that is never answered.
      @(posedge clk); #1;
      force_busy = 1'b1; mute = 1'b1;
      @(posedge clk); #1;
      ops.delete();
      mem_addr = 32'h0400_0010; mem_wstrb = 4'b0000; mem_valid = 1'b1; sel = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("busy_hold", 64'(sd_rd_enable), 64'd0);
      end
      check("pre_to_err", 64'(err), 64'd0);
      @(posedge clk); #1;
      force_busy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (sd_rd_enable) seen = 1'b1;
      end
      check("to_enable", 64'(seen), 64'd1);
      el = 0; seen = 1'b0;
      for (int i = 0; i < int'(TO) + 20 && !seen; i++) begin
         @(negedge clk);
         el++;
         if (mem_ready) seen = 1'b1;
      end
      check("to_ready", 64'(seen), 64'd1);
      check("to_err", 64'(err), 64'd1);
      check("to_rdata", 64'(mem_rdata), 64'hFFFF_FFFF);
      check("to_latency", 64'(el >= TO && el <= TO + 3), 64'd1);
      check("to_ops", 64'(ops.size()), 64'd1);
      @(posedge clk); #1;
      mem_valid = 1'b0; sel = 1'b0; mute = 1'b0;
      repeat (3) @(negedge clk);
      check("err_sticky", 64'(err), 64'd1);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("err_cleared", 64'(err), 64'd0);

      // Reset while waiting on the high-half read.
      fix_lat = 6;
      @(posedge clk); #1;
      ops.delete();
      r0 = n_ready;
      mem_addr = 32'h0000_0100; mem_wstrb = 4'b0000; mem_valid = 1'b1; sel = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (ops.size() >= 2) seen = 1'b1;
      end
      check("mid_hi_enable", 64'(seen), 64'd1);
      @(posedge clk); #1;
      reset = 1'b1; mem_valid = 1'b0; sel = 1'b0;
      @(negedge clk);
      check("mid_ready", 64'(mem_ready), 64'd0);
      check("mid_en", 64'({sd_rd_enable, sd_wr_enable}), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_addr", 64'(sd_addr), 64'd0);
      check("mid_rdata", 64'(mem_rdata), 64'd0);
      repeat (8) @(negedge clk);
      check("mid_ops", 64'(ops.size()), 64'd2);
      check("mid_nready", 64'(n_ready), 64'(r0));
      fix_lat = 0;
      do_txn(32'h0000_0100, 32'h0, 4'b0000, got);
      do_txn(32'h0000_0104, 32'h1357_9BDF, 4'b0110, got);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
